ubs2bin_bi: RTL

Bipolar unary-bitstream-to-binary decoder for the stream produced by the bipolar scaled unary MAC (`oC`). It counts ones over a fixed window of 2^WIDTH cycles and converts the count to a signed bipolar value. It presents that value on a valid/ready output handshake. It closes the loop for unary MAC arrays by returning results to the binary domain for checking, accumulation or storage.

---
 rtl/ubs2bin_bi.sv | 86 ++++++++
 1 files changed

// File: rtl/ubs2bin_bi.sv
// Bipolar unary-bitstream decoder: counts ones over a 2^WIDTH-cycle window and
// presents 2*ones - 2^WIDTH on a valid/ready output.
module ubs2bin_bi #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iStart,
    input  logic                    iBit,
    output logic                    oBusy,
    output logic signed [WIDTH+1:0] oData,
    output logic                    oValid,
    input  logic                    iReady
);

    typedef enum logic [1:0] {StIdle, StCount, StHold} state_e;

    localparam logic [WIDTH+1:0] Window = (WIDTH+2)'(1) << WIDTH;

    state_e                  r_state, w_state_d;
    logic [WIDTH:0]          r_ones, w_ones_d;
    logic [WIDTH-1:0]        r_cnt, w_cnt_d;
    logic signed [WIDTH+1:0] r_data, w_data_d;

    logic [WIDTH:0]          w_ones_inc;
    logic [WIDTH+1:0]        w_final;

    // The bit sampled on the last window cycle is folded into the result.
    assign w_ones_inc = r_ones + {{WIDTH{1'b0}}, iBit};
    assign w_final    = {w_ones_inc, 1'b0} - Window;

    always_comb begin
        w_state_d = r_state;
        w_ones_d  = r_ones;
        w_cnt_d   = r_cnt;
        w_data_d  = r_data;
        case (r_state)
            StIdle: begin
                if (iStart) begin
                    w_state_d = StCount;
                    w_ones_d  = '0;
                    w_cnt_d   = '0;
                end
            end
            StCount: begin
                w_ones_d = w_ones_inc;
                w_cnt_d  = r_cnt + WIDTH'(1);
                if (r_cnt == '1) begin
                    w_data_d  = w_final;
                    w_state_d = StHold;
                end
            end
            StHold: begin
                if (iReady) begin
                    if (iStart) begin
                        w_state_d = StCount;
                        w_ones_d  = '0;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ones  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_ones  <= w_ones_d;
            r_cnt   <= w_cnt_d;
            r_data  <= w_data_d;
        end
    end

    assign oBusy  = (r_state == StCount);
    assign oValid = (r_state == StHold);
    assign oData  = r_data;

endmodule
